// File: rtl/param_regfile_sb_if.sv
// Bus bundle for param_regfile_sb.
// master: the datapath side (drives write/read/issue requests, observes data,
//         hazard and occupancy).
// slave : the register file itself.
// Signals:
//   regWrite, rd1, rd2, select, writeData : write request and destination pick
//   rs, rt                                : read addresses (combinational ports)
//   issueValid, issueReg                  : mark a register as having a result in flight
//   outR0, outR1                          : read data for rs / rt
//   hazard                                : a read source is still waiting on its producer
//   pendCount                             : registered number of pending registers
interface param_regfile_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              regWrite;
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [ADDR_W-1:0] rd1;
   logic [ADDR_W-1:0] rd2;
   logic              select;
   logic [DATA_W-1:0] writeData;
   logic              issueValid;
   logic [ADDR_W-1:0] issueReg;
   logic [DATA_W-1:0] outR0;
   logic [DATA_W-1:0] outR1;
   logic              hazard;
   logic [ADDR_W:0]   pendCount;

   modport master (
      output regWrite, rs, rt, rd1, rd2, select, writeData, issueValid, issueReg,
      input  outR0, outR1, hazard, pendCount
   );

   modport slave (
      input  regWrite, rs, rt, rd1, rd2, select, writeData, issueValid, issueReg,
      output outR0, outR1, hazard, pendCount
   );
endinterface

// File: rtl/param_regfile_sb.sv
// Parametrised two-read / one-write register file with a per-register
// pending scoreboard.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset (clears registers and scoreboard)
//   bus   : param_regfile_sb_if.slave (write, read, issue, hazard, occupancy)
// Reads are combinational. With BYPASS=1 a write in flight this cycle is
// forwarded to a matching read port and also clears the hazard for it.
// With ZERO_REG=1 register 0 reads as zero and never becomes pending.
module param_regfile_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   param_regfile_sb_if.slave    bus
);
   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_regs [NREG];
   logic [NREG-1:0]   r_pend;
   logic [ADDR_W:0]   r_pend_cnt;

   logic [ADDR_W-1:0] w_des;
   logic [NREG-1:0]   w_pend_next;
   logic [ADDR_W:0]   w_pend_cnt_next;
   logic              w_wr_drop;
   logic              w_fwd_rs;
   logic              w_fwd_rt;
   logic              w_zero_rs;
   logic              w_zero_rt;
   logic              w_hz_rs;
   logic              w_hz_rt;

   assign w_des     = bus.select ? bus.rd2 : bus.rd1;
   assign w_wr_drop = (ZERO_REG != 0) && (w_des == '0);

   // Forwarding match per read port; only meaningful when BYPASS is enabled.
   assign w_fwd_rs  = (BYPASS != 0) && bus.regWrite && (w_des == bus.rs);
   assign w_fwd_rt  = (BYPASS != 0) && bus.regWrite && (w_des == bus.rt);
   assign w_zero_rs = (ZERO_REG != 0) && (bus.rs == '0);
   assign w_zero_rt = (ZERO_REG != 0) && (bus.rt == '0);

   // Zero register wins over forwarding.
   assign bus.outR0 = w_zero_rs ? '0 : (w_fwd_rs ? bus.writeData : r_regs[bus.rs]);
   assign bus.outR1 = w_zero_rt ? '0 : (w_fwd_rt ? bus.writeData : r_regs[bus.rt]);

   // A pending source is not a hazard if its result is being written now and
   // can be forwarded.
   assign w_hz_rs    = r_pend[bus.rs] & ~w_fwd_rs;
   assign w_hz_rt    = r_pend[bus.rt] & ~w_fwd_rt;
   assign bus.hazard = w_hz_rs | w_hz_rt;

   assign bus.pendCount = r_pend_cnt;

   // Next scoreboard: clear on write first, then set on issue so a new
   // producer issued in the same cycle supersedes the completing one.
   always_comb begin
      w_pend_next = r_pend;
      if (bus.regWrite) begin
         w_pend_next[w_des] = 1'b0;
      end
      if (bus.issueValid) begin
         w_pend_next[bus.issueReg] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         w_pend_next[0] = 1'b0;
      end
   end

   // Occupancy is registered alongside the pending bits, so it is the
   // popcount of the next-state vector.
   always_comb begin
      w_pend_cnt_next = '0;
      for (int i = 0; i < NREG; i++) begin
         w_pend_cnt_next = w_pend_cnt_next + {{ADDR_W{1'b0}}, w_pend_next[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
         r_pend     <= '0;
         r_pend_cnt <= '0;
      end else begin
         if (bus.regWrite && !w_wr_drop) begin
            r_regs[w_des] <= bus.writeData;
         end
         r_pend     <= w_pend_next;
         r_pend_cnt <= w_pend_cnt_next;
      end
   end
endmodule

// File: tb/tb_param_regfile_sb.sv
module tb_param_regfile_sb;
   localparam int DW = 16;
   localparam int AW = 3;
   localparam int NR = 8;

   logic clk;
   logic reset;

   param_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
   param_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

   // dut_a: plain register 0, forwarding on. dut_b: zero register, no forwarding.
   param_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(1)) dut_a (
      .clk(clk), .reset(reset), .bus(if_a)
   );
   param_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_b (
      .clk(clk), .reset(reset), .bus(if_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: architectural register contents and pending flags
   logic [DW-1:0] m_regs [2][NR];
   bit            m_pend [2][NR];
   bit            m_zr   [2] = '{1'b0, 1'b1};
   bit            m_byp  [2] = '{1'b1, 1'b0};

   int errors = 0;
   int checks = 0;

   // current stimulus
   logic          s_rw, s_sel, s_iv;
   logic [AW-1:0] s_rs, s_rt, s_rd1, s_rd2, s_ir;
   logic [DW-1:0] s_wd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_read(input int d, input logic [AW-1:0] a);
      int des;
      des = s_sel ? int'(s_rd2) : int'(s_rd1);
      if (m_zr[d] && a == 0) return '0;
      if (m_byp[d] && s_rw && des == int'(a)) return s_wd;
      return m_regs[d][a];
   endfunction

   function automatic logic exp_hz(input int d, input logic [AW-1:0] a);
      int des;
      des = s_sel ? int'(s_rd2) : int'(s_rd1);
      return m_pend[d][a] && !(m_byp[d] && s_rw && des == int'(a));
   endfunction

   function automatic int pend_total(input int d);
      int n = 0;
      for (int i = 0; i < NR; i++) n += m_pend[d][i] ? 1 : 0;
      return n;
   endfunction

   task automatic model_edge();
      int des;
      des = s_sel ? int'(s_rd2) : int'(s_rd1);
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            for (int i = 0; i < NR; i++) begin
               m_regs[d][i] = '0;
               m_pend[d][i] = 1'b0;
            end
         end else begin
            if (s_rw && !(m_zr[d] && des == 0)) m_regs[d][des] = s_wd;
            if (s_rw) m_pend[d][des] = 1'b0;
            if (s_iv) m_pend[d][s_ir] = 1'b1;
            if (m_zr[d]) m_pend[d][0] = 1'b0;
         end
      end
   endtask

   task automatic drive(input logic rst, input logic rw, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic [AW-1:0] rd1,
                        input logic [AW-1:0] rd2, input logic sel, input logic [DW-1:0] wd,
                        input logic iv, input logic [AW-1:0] ir);
      reset = rst;
      s_rw = rw; s_rs = rs; s_rt = rt; s_rd1 = rd1; s_rd2 = rd2;
      s_sel = sel; s_wd = wd; s_iv = iv; s_ir = ir;
      if_a.regWrite = rw; if_a.rs = rs; if_a.rt = rt; if_a.rd1 = rd1; if_a.rd2 = rd2;
      if_a.select = sel; if_a.writeData = wd; if_a.issueValid = iv; if_a.issueReg = ir;
      if_b.regWrite = rw; if_b.rs = rs; if_b.rt = rt; if_b.rd1 = rd1; if_b.rd2 = rd2;
      if_b.select = sel; if_b.writeData = wd; if_b.issueValid = iv; if_b.issueReg = ir;
   endtask

   // One cycle: check combinational outputs before the edge, update the
   // model on the edge, then check the registered occupancy.
   task automatic step(input logic rst, input logic rw, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt, input logic [AW-1:0] rd1,
                       input logic [AW-1:0] rd2, input logic sel, input logic [DW-1:0] wd,
                       input logic iv, input logic [AW-1:0] ir);
      drive(rst, rw, rs, rt, rd1, rd2, sel, wd, iv, ir);
      #2;
      check("a_outR0", 32'(if_a.outR0), 32'(exp_read(0, rs)));
      check("a_outR1", 32'(if_a.outR1), 32'(exp_read(0, rt)));
      check("a_hazard", 32'(if_a.hazard), 32'(exp_hz(0, rs) | exp_hz(0, rt)));
      check("b_outR0", 32'(if_b.outR0), 32'(exp_read(1, rs)));
      check("b_outR1", 32'(if_b.outR1), 32'(exp_read(1, rt)));
      check("b_hazard", 32'(if_b.hazard), 32'(exp_hz(1, rs) | exp_hz(1, rt)));
      @(posedge clk);
      model_edge();
      #1;
      check("a_pendCount", 32'(if_a.pendCount), 32'(pend_total(0)));
      check("b_pendCount", 32'(if_b.pendCount), 32'(pend_total(1)));
      @(negedge clk);
   endtask

   initial begin
      // initial reset, outputs undefined before it so nothing is compared
      drive(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 3'd0);
      @(posedge clk);
      model_edge();
      @(negedge clk);

      // read every address after reset
      for (int i = 0; i < NR; i++)
         step(1'b0, 1'b0, 3'(i), 3'(NR - 1 - i), 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 3'd0);

      // rd2 selected, forward to rs=5, rt=2 stays zero
      step(1'b0, 1'b1, 3'd5, 3'd2, 3'd2, 3'd5, 1'b1, 16'hBEEF, 1'b0, 3'd0);
      step(1'b0, 1'b0, 3'd5, 3'd2, 3'd2, 3'd5, 1'b1, 16'h0000, 1'b0, 3'd0);

      // issue 3, observe hazard, resolve with a write
      step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b1, 3'd3);
      step(1'b0, 1'b0, 3'd3, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 3'd0);
      step(1'b0, 1'b1, 3'd3, 3'd1, 3'd3, 3'd0, 1'b0, 16'h1234, 1'b0, 3'd0);
      step(1'b0, 1'b0, 3'd3, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 3'd0);

      // set wins over clear; issue 1 with write 6 keeps the count
      step(1'b0, 1'b0, 3'd6, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0, 1'b1, 3'd6);
      step(1'b0, 1'b1, 3'd4, 3'd6, 3'd4, 3'd0, 1'b0, 16'hA5A5, 1'b1, 3'd4);
      step(1'b0, 1'b1, 3'd6, 3'd4, 3'd0, 3'd6, 1'b1, 16'h6666, 1'b1, 3'd1);
      step(1'b0, 1'b0, 3'd4, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0, 1'b1, 3'd4);

      // register 0 write and issue
      step(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'hFFFF, 1'b1, 3'd0);
      step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 3'd0);

      // fill some registers, mark pending, then reset with a concurrent write
      step(1'b0, 1'b1, 3'd1, 3'd2, 3'd1, 3'd0, 1'b0, 16'h1111, 1'b1, 3'd2);
      step(1'b0, 1'b1, 3'd2, 3'd7, 3'd2, 3'd0, 1'b0, 16'h2222, 1'b1, 3'd7);
      step(1'b0, 1'b1, 3'd7, 3'd1, 3'd7, 3'd0, 1'b0, 16'h7777, 1'b1, 3'd1);
      step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b1, 3'd2);
      step(1'b1, 1'b1, 3'd1, 3'd7, 3'd3, 3'd0, 1'b0, 16'hDEAD, 1'b1, 3'd5);
      for (int i = 0; i < NR; i++)
         step(1'b0, 1'b0, 3'(i), 3'(i), 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 3'd0);

      // random traffic
      for (int n = 0; n < 400; n++)
         step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 16'($urandom),
              ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
